snake_input_ctrl: RTL
=====================

# snake_input_ctrl

Input front end for the snake game engine. It synchronises and debounces the two raw active-low turn buttons, and turns each press into a single turn request held until the next game step. It also generates the game-step tick from `clk` with the two-level speed select. It sits directly upstream of the game engine, which consumes `tick_o` and `turn_o` once per frame instead of sampling raw buttons and a divided clock.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth per button, ≥2.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles before a level change is accepted (20 ms at 50 MHz).
- `TICK_W`, 25: step accumulator width.

Ports:
- `clk`: in, 1, system clock; the only clock.
- `rst_n`: in, 1, reset, synchronous, active-low.
- `btL_n`: in, 1, raw left button, active-low, asynchronous.
- `btR_n`: in, 1, raw right button, active-low, asynchronous.
- `speed_sel`: in, 1, 0 = normal, 1 = double speed; sampled every cycle.
- `tick_o`: out, 1, one-cycle game-step pulse.
- `turn_o`: out, 2, `turn_t` request; valid only while `tick_o` = 1, otherwise NONE.

## Operation
- **Synchroniser:** each button passes through a `SYNC_STAGES` flop chain. Reset value is 1 (released).
- **Debounce (per button):**
  - A counter runs while the synchronised level differs from the stable level.
  - The counter clears to 0 whenever the two levels are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`, the stable level takes the new value and the counter clears.
  - Stable reset value is 1.
- **Press event:** a stable 1→0 transition produces one cycle of `press`. Release produces nothing. A held button produces exactly one event; there is no auto-repeat.
- **Pending register** (`turn_t`, reset NONE). Priority each cycle, highest first:
  1. Reset: pending ← NONE.
  2. Left and right press in the same cycle: pending unchanged.
  3. Single press: pending ← LEFT or RIGHT. The latest press overwrites an earlier one, including the opposite direction.
  4. `tick_o` asserted this cycle: pending ← NONE, unless rule 3 also applies in the same cycle, in which case the new press is kept for the next step.
- **Step accumulator:**
  - `acc` is `TICK_W` bits, reset 0.
  - Adds `speed_sel ? 2 : 1` each cycle and wraps modulo 2^`TICK_W`.
  - `tick_o` is registered: it asserts the cycle after `acc[TICK_W-1]` rises 0→1.
  - Period is 2^`TICK_W` cycles at normal speed and 2^(`TICK_W`-1) cycles at double speed.
  - Changing `speed_sel` takes effect from the next addition. There is no reset of `acc` and no extra tick.
- **Turn output:** `turn_o` is registered together with `tick_o` and carries the pending value at the cycle `tick_o` is generated. It is NONE in every other cycle.

## Timing
- All outputs are 0 / NONE during reset and on the first cycle after reset release.
- **Press latency:** raw falling edge held stable → `press` after `SYNC_STAGES` + `DEBOUNCE_CYCLES` cycles. Pending updates 1 cycle later.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_CYCLES` cycles, after synchronisation, never changes the stable level.
- **First tick:** `tick_o` first asserts 2^(`TICK_W`-1) + 1 cycles after reset release at normal speed, then every period.
- **Mid-operation reset:** clears sync, debounce, pending, `acc` and outputs in the same edge. A request pending at reset is lost.

## Structure
- **Package `snake_pkg`:**
  - `typedef enum logic [1:0] turn_t {TURN_NONE=2'b00, TURN_LEFT=2'b01, TURN_RIGHT=2'b10}`.
  - Speed increment constants `SPEED_NORM`=1 and `SPEED_FAST`=2.
- **Sub-module `btn_debounce`:** one instance per button. Parameters `SYNC_STAGES` and `DEBOUNCE_CYCLES`; ports `clk`, `rst_n`, `raw_n`, `stable_n`, `press`.
- The top level holds the pending register, the accumulator and the output registers.

## Test plan
All scenarios use `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `TICK_W`=4.
1. **Reset and tick rate:** hold `rst_n` low 3 cycles, then release with `speed_sel`=0. Expect `tick_o` first at cycle 9 after release, then every 16 cycles, with `turn_o`=NONE on each. Set `speed_sel`=1: period becomes 8.
2. **Debounce rejection:** drive `btL_n` low for 3 cycles, then high. Expect no press, and the next tick reports NONE. Drive it low for 10 cycles: pending = LEFT at cycle 7; the next tick reports LEFT, and the tick after that reports NONE.
3. **Overwrite:** LEFT press, then RIGHT press within the same tick window. Expect the tick to report RIGHT, exactly once.
4. **Simultaneous presses:** raw falling edges of both buttons on the same cycle (identical press cycles) → next tick reports NONE. Then RIGHT pending with a new LEFT press landing on the tick cycle → this tick reports RIGHT, the following tick reports LEFT.
5. **Held button:** hold `btR_n` low across 5 ticks. Expect RIGHT on exactly one tick and NONE on the other four.
6. **Reset mid-operation:** LEFT pending, then pulse `rst_n` low for 1 cycle. Expect pending NONE, `acc` 0, and no LEFT reported on later ticks.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game input front end.
package snake_pkg;

    typedef enum logic [1:0] {
        TURN_NONE  = 2'b00,
        TURN_LEFT  = 2'b01,
        TURN_RIGHT = 2'b10
    } turn_t;

    localparam logic [1:0] SPEED_NORM = 2'd1;
    localparam logic [1:0] SPEED_FAST = 2'd2;

endpackage

// File: rtl/btn_debounce.sv
// One button: flop-chain synchroniser, stable-level debounce filter, and a
// single-cycle press pulse on each accepted 1->0 change of the stable level.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic stable_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_press;
    logic                   w_sync;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign stable_n = r_stable;
    assign press    = r_press;

    // The counter only advances while the synchronised level disagrees with
    // the stable one; the final disagreeing cycle commits the new level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync   <= '1;
            r_cnt    <= '0;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], raw_n};
            r_press <= 1'b0;
            if (w_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= w_sync;
                r_cnt    <= '0;
                r_press  <= ~w_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_input_ctrl.sv
// Snake input front end: debounced turn buttons folded into one pending turn
// request, released to the engine together with the game-step tick.
module snake_input_ctrl
    import snake_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_W          = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btL_n,
    input  logic       btR_n,
    input  logic       speed_sel,
    output logic       tick_o,
    output logic [1:0] turn_o
);

    logic              w_press_l_raw, w_press_r_raw;
    logic              w_stable_l, w_stable_r;
    logic              w_press_l, w_press_r;
    logic              w_tick_next;
    logic [TICK_W-1:0] w_inc;

    turn_t             r_pending;
    turn_t             r_turn;
    logic [TICK_W-1:0] r_acc;
    logic              r_msb_d;
    logic              r_tick;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_l (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_n   (btL_n),
        .stable_n(w_stable_l),
        .press   (w_press_l_raw)
    );

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_n   (btR_n),
        .stable_n(w_stable_r),
        .press   (w_press_r_raw)
    );

    // A press always coincides with the stable level having gone low.
    assign w_press_l   = w_press_l_raw & ~w_stable_l;
    assign w_press_r   = w_press_r_raw & ~w_stable_r;

    assign w_inc       = speed_sel ? TICK_W'(SPEED_FAST) : TICK_W'(SPEED_NORM);
    assign w_tick_next = r_acc[TICK_W-1] & ~r_msb_d;

    assign tick_o = r_tick;
    assign turn_o = r_turn;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= TURN_NONE;
            r_turn    <= TURN_NONE;
            r_acc     <= '0;
            r_msb_d   <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_acc   <= r_acc + w_inc;
            r_msb_d <= r_acc[TICK_W-1];
            r_tick  <= w_tick_next;
            r_turn  <= w_tick_next ? r_pending : TURN_NONE;

            // Contradictory simultaneous presses leave the request untouched;
            // a fresh press survives a step that is consuming the old one.
            if (w_press_l && w_press_r) begin
                r_pending <= r_pending;
            end else if (w_press_l) begin
                r_pending <= TURN_LEFT;
            end else if (w_press_r) begin
                r_pending <= TURN_RIGHT;
            end else if (r_tick) begin
                r_pending <= TURN_NONE;
            end
        end
    end

endmodule
